// File: rtl/bram_mult_pkg.sv
// Shared types and operand-packing constants for the BRAM-fed multiply sequencer.
// A RAM word holds one operand pair packed as {b, a}.
package bram_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int A_LSB = 0;

  function automatic int b_lsb(input int width);
    return A_LSB + width;
  endfunction

endpackage

// File: rtl/bram_mult_seq_mult_pipe.sv
// Unsigned WIDTH x WIDTH multiplier followed by MULT_STAGES register stages with a
// travelling valid bit; the final stage holds its product while no new one arrives.
module mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int MULT_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_vld,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 pend
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int LAST   = MULT_STAGES - 1;

  logic [PROD_W-1:0]      prod_full;
  logic [PROD_W-1:0]      prod_q [MULT_STAGES];
  logic [PROD_W-1:0]      prod_d [MULT_STAGES];
  logic [MULT_STAGES-1:0] vld_q;
  logic [MULT_STAGES-1:0] vld_d;

  // Full-width product; the delay stages behind it let synthesis retime the array.
  assign prod_full = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    prod_d[0] = in_vld ? prod_full : prod_q[0];
    for (int k = 1; k < MULT_STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      prod_d[k] = vld_q[k-1] ? prod_q[k-1] : prod_q[k];
    end
    // Anything not yet at the output stage counts as still in flight.
    pend = in_vld;
    for (int k = 0; k < LAST; k++) begin
      pend = pend | vld_q[k];
    end
  end

  // Stage boundary: inner data stages carry no reset, the visible output stage does.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LAST; k++) begin
      prod_q[k] <= prod_d[k];
    end
    if (rst) begin
      vld_q        <= '0;
      prod_q[LAST] <= '0;
    end else begin
      vld_q        <= vld_d;
      prod_q[LAST] <= prod_d[LAST];
    end
  end

  assign out_vld  = vld_q[LAST];
  assign out_prod = prod_q[LAST];

endmodule

// File: rtl/bram_mult_seq.sv
// Walks a RAM of packed {b,a} operand pairs, streams them through mult_pipe and
// presents one product per cycle. Optional running sum enabled by BRAM_MULT_ACC_EN.
module bram_mult_seq
  import bram_mult_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int MULT_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  loop,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [2*WIDTH-1:0]    mem_rdata,
  output logic [2*WIDTH-1:0]    y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  done
`ifdef BRAM_MULT_ACC_EN
  ,
  output logic [2*WIDTH+ADDR_W-1:0] acc
`endif
);

  localparam int                PROD_W    = 2 * WIDTH;
  localparam int                B_LSB     = b_lsb(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              loop_q, loop_d;
  logic              rd_vld_q, rd_vld_d;
  logic              run_start;
  logic              pipe_pend;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    loop_d    = loop_q;
    mem_en    = 1'b0;
    run_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) begin
          state_d   = RUN;
          loop_d    = loop;
          addr_d    = '0;
          run_start = 1'b1;
        end
      end
      RUN: begin
        // start_stop low simply withholds the read; the address is kept for resume.
        if (start_stop) begin
          mem_en = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (!loop_q) state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!pipe_pend) state_d = DONE;
      end
      DONE: begin
        if (!start_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_vld_d = mem_en;

  // Stage boundary: read request -> RAM data valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      loop_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      loop_q   <= loop_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_vld_q),
    .in_a     (mem_rdata[A_LSB +: WIDTH]),
    .in_b     (mem_rdata[B_LSB +: WIDTH]),
    .out_vld  (y_valid),
    .out_prod (y),
    .pend     (pipe_pend)
  );

  assign mem_addr = addr_q;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

`ifdef BRAM_MULT_ACC_EN
  localparam int ACC_W = PROD_W + ADDR_W;

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (run_start)    acc_d = '0;
    else if (y_valid) acc_d = acc_q + ACC_W'(y);
  end

  // Stage boundary: product output -> running sum.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
`endif

endmodule

// File: tb/tb_bram_mult_seq.sv
// Scoreboard bench for bram_mult_seq with DEPTH=4 and a fixed four-pair operand RAM.
module tb_bram_mult_seq;

  localparam int WIDTH       = 16;
  localparam int DEPTH       = 4;
  localparam int ADDR_W      = 2;
  localparam int MULT_STAGES = 2;
  localparam int LAT         = 1 + MULT_STAGES;
  localparam int PW          = 2 * WIDTH;
  localparam int ACC_W       = PW + ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start_stop, loop;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PW-1:0]     mem_rdata;
  logic [PW-1:0]     y;
  logic              y_valid, busy, done;
`ifdef BRAM_MULT_ACC_EN
  logic [ACC_W-1:0]  acc;
  localparam logic [ACC_W-1:0] ACC_SUM = ACC_W'(64'd4294836317);
`endif

  bram_mult_seq #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MULT_STAGES(MULT_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .loop(loop),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .y(y), .y_valid(y_valid), .busy(busy), .done(done)
`ifdef BRAM_MULT_ACC_EN
    , .acc(acc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  logic [PW-1:0] ram [DEPTH];
  logic [PW-1:0] tbl [DEPTH];
  exp_t          exp_q[$];
  exp_t          push_e;
  int            addr_log[$];
  logic [PW-1:0] obs_q[$];
  int            vld_cyc[$];
  int            cyc = 0;
  int            rd_cnt = 0;
  int            total = 0;
  int            bad = 0;

  function automatic logic [PW-1:0] model_mul(input logic [PW-1:0] word);
    logic [63:0] a, b, p;
    a = 64'(word[WIDTH-1:0]);
    b = 64'(word[PW-1:WIDTH]);
    p = a * b;
    return p[PW-1:0];
  endfunction

  // RAM model; every read it serves queues the product the bench expects.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (mem_en) begin
      push_e.prod = model_mul(ram[mem_addr]);
      push_e.cyc  = cyc;
      exp_q.push_back(push_e);
      addr_log.push_back(int'(mem_addr));
      rd_cnt++;
    end
    if (mem_en) mem_rdata <= ram[mem_addr];
    cyc++;
  end

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (y_valid === 1'b1) begin
      obs_q.push_back(y);
      vld_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_valid: y=%0h but no product pending", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e.prod) begin
          bad++;
          $display("FAIL sb_product: got=%0h want=%0h", y, e.prod);
        end
        total++;
        if (cyc - e.cyc != LAT) begin
          bad++;
          $display("FAIL sb_latency: got=%0d want=%0d", cyc - e.cyc, LAT);
        end
      end
    end
  endtask

  task automatic clear_logs();
    obs_q.delete();
    vld_cyc.delete();
    addr_log.delete();
  endtask

  task automatic check_pass(input string tag);
    total++;
    if (obs_q.size() != DEPTH) begin
      bad++;
      $display("FAIL %s_count: got=%0d want=%0d", tag, obs_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== tbl[i]) begin
        bad++;
        $display("FAIL %s_y%0d: got=%0h want=%0h", tag, i,
                 (i < obs_q.size()) ? obs_q[i] : '0, tbl[i]);
      end
      total++;
      if (i >= addr_log.size() || addr_log[i] != i) begin
        bad++;
        $display("FAIL %s_addr%0d: got=%0d want=%0d", tag, i,
                 (i < addr_log.size()) ? addr_log[i] : -1, i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_stop = 1'b0; loop = 1'b0;
    repeat (3) tick();
    total++;
    if ({mem_en, y_valid, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got=%b want=0000", {mem_en, y_valid, busy, done});
    end
    total++;
    if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got=%0d want=0", mem_addr); end
    total++;
    if (y !== '0) begin bad++; $display("FAIL reset_y: got=%0h want=0", y); end
`ifdef BRAM_MULT_ACC_EN
    total++;
    if (acc !== '0) begin bad++; $display("FAIL reset_acc: got=%0d want=0", acc); end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got=%b want=0", busy); end
  endtask

  task automatic test_single_pass();
    bit got;
    int done_cyc;
    clear_logs();
    loop = 1'b0; start_stop = 1'b1;
    tick();
    total++;
    if (busy !== 1'b1 || mem_en !== 1'b1) begin
      bad++; $display("FAIL pass_start: busy=%b mem_en=%b want 1 1", busy, mem_en);
    end
`ifdef BRAM_MULT_ACC_EN
    total++;
    if (acc !== '0) begin bad++; $display("FAIL pass_acc0: got=%0d want=0", acc); end
`endif
    got = 0; done_cyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (done === 1'b1) begin got = 1; done_cyc = cyc; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL pass_done: got=0 want=1 within 40 cycles"); end
    check_pass("pass");
    if (vld_cyc.size() == DEPTH) begin
      total++;
      if (vld_cyc[DEPTH-1] - vld_cyc[0] != DEPTH - 1) begin
        bad++; $display("FAIL pass_consecutive: span=%0d want=%0d", vld_cyc[DEPTH-1] - vld_cyc[0], DEPTH - 1);
      end
      total++;
      if (done_cyc != vld_cyc[DEPTH-1] + 1) begin
        bad++; $display("FAIL pass_done_timing: got=%0d want=%0d", done_cyc, vld_cyc[DEPTH-1] + 1);
      end
    end
`ifdef BRAM_MULT_ACC_EN
    total++;
    if (acc !== ACC_SUM) begin bad++; $display("FAIL pass_acc: got=%0d want=%0d", acc, ACC_SUM); end
`endif
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL pass_done_hold: got=%b want=1", done); end
    start_stop = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL pass_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_pause();
    int base, snap;
    bit got;
    clear_logs();
    base = rd_cnt; start_stop = 1'b1;
    for (int i = 0; i < 10 && rd_cnt - base < 2; i++) tick();
    start_stop = 1'b0;
    snap = rd_cnt;
    repeat (5) tick();
    total++;
    if (rd_cnt != snap) begin bad++; $display("FAIL pause_reads: got=%0d want=%0d", rd_cnt - snap, 0); end
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL pause_inflight: got=%0d want=2", obs_q.size()); end
    total++;
    if (busy !== 1'b1 || mem_addr !== 2'd2) begin
      bad++; $display("FAIL pause_hold: busy=%b addr=%0d want 1 2", busy, mem_addr);
    end
    start_stop = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (done === 1'b1) got = 1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL pause_done: got=0 want=1 within 40 cycles"); end
    check_pass("pause");
    start_stop = 1'b0;
    tick();
  endtask

  task automatic test_rerun_drain_stop();
    int base;
    bit got;
    clear_logs();
    base = rd_cnt; start_stop = 1'b1;
    tick();
`ifdef BRAM_MULT_ACC_EN
    total++;
    if (acc !== '0) begin bad++; $display("FAIL rerun_acc0: got=%0d want=0", acc); end
`endif
    for (int i = 0; i < 10 && rd_cnt - base < DEPTH; i++) tick();
    // Stop request lands while draining and must not abort the pass.
    start_stop = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (done === 1'b1) got = 1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL rerun_done: got=0 want=1 within 20 cycles"); end
    check_pass("rerun");
`ifdef BRAM_MULT_ACC_EN
    total++;
    if (acc !== ACC_SUM) begin bad++; $display("FAIL rerun_acc: got=%0d want=%0d", acc, ACC_SUM); end
`endif
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL rerun_idle: done=%b want=0", done); end
  endtask

  task automatic test_loop();
    int base, base2, done_seen;
    clear_logs();
    base = rd_cnt; done_seen = 0;
    loop = 1'b1; start_stop = 1'b1;
    for (int i = 0; i < 20 && rd_cnt - base < 10; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= addr_log.size() || addr_log[i] != i % DEPTH) begin
        bad++; $display("FAIL loop_addr%0d: got=%0d want=%0d", i,
                        (i < addr_log.size()) ? addr_log[i] : -1, i % DEPTH);
      end
    end
    total++;
    if (obs_q.size() < 7) begin bad++; $display("FAIL loop_count: got=%0d want>=7", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== tbl[i % DEPTH]) begin
        bad++; $display("FAIL loop_y%0d: got=%0h want=%0h", i, obs_q[i], tbl[i % DEPTH]);
      end
    end
    // loop is only sampled in IDLE, so clearing it now must not end the run.
    loop = 1'b0;
    base2 = rd_cnt;
    repeat (6) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    total++;
    if (rd_cnt - base2 != 6) begin bad++; $display("FAIL loop_latched: reads=%0d want=6", rd_cnt - base2); end
    total++;
    if (done_seen != 0) begin bad++; $display("FAIL loop_done: got=%0d want=0", done_seen); end
    rst = 1'b1; start_stop = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int base, vcount;
    clear_logs();
    base = rd_cnt; loop = 1'b0; start_stop = 1'b1;
    for (int i = 0; i < 10 && rd_cnt - base < 2; i++) tick();
    total++;
    if (rd_cnt - base != 2) begin bad++; $display("FAIL rstmid_reads: got=%0d want=2", rd_cnt - base); end
    rst = 1'b1; start_stop = 1'b0;
    tick();
    total++;
    if ({mem_en, y_valid, busy, done} !== 4'b0 || y !== '0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: ctrl=%b y=%0h addr=%0d want all 0",
               {mem_en, y_valid, busy, done}, y, mem_addr);
    end
    rst = 1'b0;
    vcount = 0;
    repeat (8) begin
      tick();
      if (y_valid === 1'b1) vcount++;
    end
    total++;
    if (vcount != 0) begin bad++; $display("FAIL rstmid_valid: got=%0d want=0", vcount); end
  endtask

  initial begin
    ram[0] = {16'd5, 16'd3};
    ram[1] = {16'd11, 16'd7};
    ram[2] = {16'hFFFF, 16'hFFFF};
    ram[3] = {16'd9, 16'd0};
    tbl[0] = 32'd15;
    tbl[1] = 32'd77;
    tbl[2] = 32'hFFFE0001;
    tbl[3] = 32'd0;
    rst = 1'b1; start_stop = 1'b0; loop = 1'b0;
    test_reset();
    test_single_pass();
    test_pause();
    test_rerun_drain_stop();
    test_loop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
